// File: rtl/tinyalu_master.sv
// tinyalu_master: queues start/done ALU commands in a FIFO, issues them one
// at a time and returns tagged results in command order.
module tinyalu_master #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_op,
  output logic [15:0] rsp_result,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  state_e        state_q, state_d;
  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cmd_t          cur_q, cur_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [2:0]    rsp_op_q, rsp_op_d;
  logic [15:0]   rsp_result_q, rsp_result_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  logic push, pop, full, empty;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign cmd_ready = !reset && !full;
  assign push      = cmd_valid && cmd_ready;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = '{op: cmd_op, a: cmd_a, b: cmd_b};
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    wcnt_d        = wcnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_op_d      = rsp_op_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    pop           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && alu_done) begin
          pop   = 1'b1;
          cur_d = mem_q[rd_q];
          if (cur_d.op == 3'd5 || cur_d.op == 3'd6) begin
            cur_d.b = {6'b0, mem_q[rd_q].b[1:0]};
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (alu_done) begin
          rsp_valid_d   = 1'b1;
          rsp_op_d      = cur_q.op;
          rsp_result_d  = alu_result;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
          if (wcnt_d == 8'(TIMEOUT)) begin
            rsp_valid_d   = 1'b1;
            rsp_op_d      = cur_q.op;
            rsp_result_d  = '0;
            rsp_timeout_d = 1'b1;
            state_d       = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands reach the ALU only while a command is in flight: op 5
  // writes the ALU register map on every cycle it is present.
  always_comb begin
    alu_op    = '0;
    alu_A     = '0;
    alu_B     = '0;
    alu_start = 1'b0;
    if (state_q == ISSUE || state_q == WAIT) begin
      alu_op = cur_q.op;
      alu_A  = cur_q.a;
      alu_B  = cur_q.b;
    end
    if (state_q == ISSUE) begin
      alu_start = 1'b1;
    end else if (state_q == WAIT) begin
      alu_start = !alu_done;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != IDLE) || !empty;

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    cur_q <= cur_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_q          <= '0;
      rd_q          <= '0;
      cnt_q         <= '0;
      wcnt_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_op_q      <= '0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      wcnt_q        <= wcnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_op_q      <= rsp_op_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule

// File: doc/tinyalu_master.md
# tinyalu_master

Initiator for the tinyalu start/done command interface. Accepts operation commands from an upstream valid/ready stream and queues them in a small FIFO. Issues one command at a time to the ALU, holding operands and `start` until `done` returns, and returns each captured result, tagged with a timeout flag, on a downstream valid/ready stream in command order. It sits between the test/sequence layer and the ALU.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT`, 15: maximum cycles to wait in WAIT for `alu_done` before aborting; ≥4, fits in 8 bits.

- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO not full; 0 while `reset`=1.
- `cmd_op`  in  3  opcode: 0 nop, 1 add, 4 and, 5 write, 6 read.
- `cmd_a`  in  8  operand A.
- `cmd_b`  in  8  operand B.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  downstream accepts response.
- `rsp_op`  out  3  opcode of the completed command.
- `rsp_result`  out  16  captured `alu_result`; 0 on timeout.
- `rsp_timeout`  out  1  command aborted by timeout.
- `busy`  out  1  FSM not IDLE or FIFO not empty.
- `alu_A`, `alu_B`  out  8 each  operands to ALU.
- `alu_op`  out  3  opcode to ALU.
- `alu_start`  out  1  start request.
- `alu_done`  in  1  ALU idle/complete (high when idle).
- `alu_result`  in  16  ALU result; valid while `alu_op` is held.

## Operation
- Push: on `cmd_valid && cmd_ready`, write {op,a,b} to FIFO; `cmd_ready = !full`.
- FSM states and transitions:
  - IDLE to ISSUE: FIFO non-empty and `alu_done`=1. Pop the head into the operand registers.
  - ISSUE to WAIT: unconditional, one cycle.
  - WAIT to RESP: on `alu_done`=1, or when the wait counter reaches `TIMEOUT`.
  - RESP to IDLE: on `rsp_ready`=1.
- `alu_op`, `alu_A` and `alu_B` are driven from the operand registers in ISSUE and WAIT only. They are 0 in IDLE and RESP, because the ALU writes its register map every cycle `op`=5 is present.
- For op 5/6, `alu_B = {6'b0, cmd_b[1:0]}`. For all other ops, `alu_B = cmd_b`.
- `alu_start` = 1 in ISSUE. In WAIT, `alu_start = !alu_done`; it is combinational so the ALU never sees `start` with `done`=1 and retriggers. `alu_start` = 0 in IDLE and RESP.
- Capture: in WAIT, when `alu_done`=1, register `alu_result` and the op, with timeout=0.
- Timeout:
  - The counter clears on entry to WAIT and increments each WAIT cycle with `alu_done`=0.
  - At `TIMEOUT`: capture result 0 with timeout=1 and drop `alu_start`/`alu_op`.
  - The next issue still waits for `alu_done`=1 in IDLE.
- Response: `rsp_*` registers are stable while `rsp_valid`=1 and are not overwritten until accepted.
- Simultaneous push with FIFO pop in the same cycle is legal when not full; the FIFO is full only when count=`DEPTH`.
- Ops 0, 2, 3, 7 are forwarded unchanged; op 2 and 3 complete with the add timing.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 after. `rsp_valid`=0, `rsp_op`=0, `rsp_result`=0, `rsp_timeout`=0, `alu_start`=0, `alu_op`=0, `alu_A`=0, `alu_B`=0, `busy`=0. FSM goes to IDLE and the FIFO empties.
- Reset mid-operation: all in-flight and queued commands are discarded with no response. `alu_start`/`alu_op` go to 0 on the next edge.
- Best case with a fresh command into an empty FIFO against tinyalu:
  - Push at edge 0, ISSUE at edge 1.
  - Add: `done` falls after ISSUE, returns about 3 edges later, `rsp_valid` about 5 cycles after push.
  - Write/read: 1 cycle shorter.
- `rsp_valid` rises the cycle after capture. With `rsp_ready` held high, back-to-back commands are spaced by at least IDLE + ISSUE + WAIT + RESP.
- Response order equals command order.

## Test plan
- Single add, A=0x12, B=0x34, op 1 → one response: `rsp_op`=1, `rsp_result`=0x0046, `rsp_timeout`=0. `alu_start` never high while `alu_done`=1 after ISSUE.
- Write then read: op 5 with A=0xA5, B=2, then op 6 with B=2 → responses are (5, 0x0000) then (6, 0x00A5). `alu_op`=0 outside ISSUE/WAIT. Register 0 still reads 0.
- Back-pressure, `DEPTH`=4, `rsp_ready`=0 → exactly 5 commands accepted before `cmd_ready`=0. Raising `rsp_ready` drains 5 in-order responses; `cmd_ready` returns to 1.
- Timeout: an ALU stub holds `alu_done`=0 after start → after 15 WAIT cycles, `rsp_timeout`=1, `rsp_result`=0. The next command issues only after the stub raises `done`.
- Reset asserted in WAIT with 2 queued commands → next cycle `alu_start`=0, `alu_op`=0, `rsp_valid`=0, `busy`=0, `cmd_ready`=1 after release, and no responses emitted.
- Response stall: `rsp_ready` held low 10 cycles → `rsp_*` stable and no new `alu_start` issued.
